daqo_queue: RTL and testbench
=============================

DAQO_QUEUE -- requirements
Module: daqo_queue

Interface
REQ-001 Parameter MAC_PACKET_BITS, default 9: width of record length field (words).
REQ-002 Parameter DATA_DEPTH_BITS, default 10: data FIFO depth 2^DATA_DEPTH_BITS 32-bit words.
REQ-003 Parameter LEN_DEPTH_BITS, default 4: length FIFO depth 2^LEN_DEPTH_BITS entries.
REQ-004 Parameter MAX_RECORD, default 375: maximum words per record; SHALL be < 2^MAC_PACKET_BITS.
REQ-005 clk  in  1  single clock; every register SHALL be clocked on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 daq_data  in  32  record word from DAQ producer.
REQ-008 daq_valid  in  1  daq_data valid this cycle.
REQ-009 daq_end  in  1  qualified by daq_valid; word is last of record.
REQ-010 daq_ready  out  1  queue can accept a word this cycle.
REQ-011 daqo_data  out  32  head word of data FIFO, first-word-fall-through.
REQ-012 daqo_data_rd_en  in  1  single-cycle pulse; pops one data word.
REQ-013 daqo_len  out  MAC_PACKET_BITS  word count of oldest committed record.
REQ-014 daqo_len_ready  out  1  length FIFO non-empty.
REQ-015 daqo_len_rd_en  in  1  single-cycle pulse; pops one length entry.
REQ-016 clear_err  in  1  pulse; clears sticky error flags.
REQ-017 overflow  out  1  sticky: word offered while daq_ready low.
REQ-018 underflow  out  1  sticky: pop requested on empty FIFO (data or length).

Function
REQ-019 Word accepted iff daq_valid && daq_ready on a clk edge; accepted word written to data FIFO tail.
REQ-020 daq_ready SHALL be registered and equal !(data FIFO full) && !(length FIFO full), reflecting state after current cycle's writes/pops.
REQ-021 Record counter rec_cnt (MAC_PACKET_BITS bits) increments per accepted word; on commit, rec_cnt returns to 0.
REQ-022 Commit: on accepted word with daq_end=1, or on accepted word making rec_cnt+1 == MAX_RECORD; length FIFO tail written with rec_cnt+1.
REQ-023 Forced commit at MAX_RECORD SHALL start a new record with the following word; a daq_end on that same word produces one commit only.
REQ-024 Records SHALL always be ≥1 word; daq_end without daq_valid is ignored.
REQ-025 Length entry SHALL become visible (daqo_len_ready=1, daqo_len valid) the cycle after the committing word's edge; its words are visible in daqo_data no later.
REQ-026 daqo_data/daqo_len present FIFO heads; each rd_en pulse advances the head by one, new head valid next cycle.
REQ-027 Consumer contract: reads exactly daqo_len data words per popped length; block performs no checking of this.
REQ-028 Pop on empty FIFO SHALL be ignored (pointers unchanged) and set underflow.
REQ-029 Simultaneous write and pop on same FIFO SHALL both take effect; occupancy unchanged.
REQ-030 Pop and write on empty FIFO in same cycle: pop ignored, underflow set, write succeeds.
REQ-031 daq_valid while daq_ready=0: word dropped, rec_cnt unchanged, overflow set; daq_end on dropped word does not commit.
REQ-032 clear_err clears overflow/underflow next cycle; a simultaneous error event wins (flag stays set).
REQ-033 Pointers SHALL wrap modulo depth; full/empty via extra pointer MSB.

Reset
REQ-034 rst asserted: daq_ready=0, daqo_len_ready=0, daqo_len=0, daqo_data=0, overflow=0, underflow=0, pointers and rec_cnt=0, immediately and asynchronously.
REQ-035 Reset mid-record or with queued data discards all contents, including partial record.
REQ-036 daq_ready SHALL rise on the first clk edge after rst deassertion.

Verification
REQ-037 Write 3 words 0x11,0x22,0x33 (end on 3rd) -> next cycle daqo_len_ready=1, daqo_len=3; three data pops return 0x11,0x22,0x33.
REQ-038 Stream 400 words, single daq_end on word 400 -> lengths 375 then 25; data order preserved.
REQ-039 Fill data FIFO (1024 words, no pops) -> daq_ready=0; extra offered word dropped, overflow=1; clear_err -> overflow=0.
REQ-040 16 one-word records, no length pops -> daq_ready=0; pop one length -> daq_ready=1 next cycle.
REQ-041 daqo_data_rd_en on empty queue -> underflow=1, later write of 0xA5 read back correctly.
REQ-042 Assert rst after 5 words of unfinished record -> all outputs at reset values; subsequent 2-word record yields daqo_len=2.

Source files
------------

// File: rtl/daqo_queue.sv
// Record queue between a DAQ word producer and a packet consumer: a data FIFO of
// 32-bit words plus a length FIFO holding the word count of each committed record.
module daqo_queue #(
    parameter int MAC_PACKET_BITS = 9,
    parameter int DATA_DEPTH_BITS = 10,
    parameter int LEN_DEPTH_BITS  = 4,
    parameter int MAX_RECORD      = 375
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                daq_data,
    input  logic                       daq_valid,
    input  logic                       daq_end,
    output logic                       daq_ready,
    output logic [31:0]                daqo_data,
    input  logic                       daqo_data_rd_en,
    output logic [MAC_PACKET_BITS-1:0] daqo_len,
    output logic                       daqo_len_ready,
    input  logic                       daqo_len_rd_en,
    input  logic                       clear_err,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DATA_DEPTH = 1 << DATA_DEPTH_BITS;
    localparam int LEN_DEPTH  = 1 << LEN_DEPTH_BITS;

    logic [31:0]                data_mem [DATA_DEPTH];
    logic [MAC_PACKET_BITS-1:0] len_mem  [LEN_DEPTH];

    logic [DATA_DEPTH_BITS:0]   data_wr, data_rd, data_wr_next, data_rd_next;
    logic [LEN_DEPTH_BITS:0]    len_wr, len_rd, len_wr_next, len_rd_next;
    logic [MAC_PACKET_BITS-1:0] rec_cnt, rec_cnt_inc;

    logic data_empty, len_empty;
    logic accept, commit, data_pop, len_pop;
    logic data_full_next, len_full_next;
    logic overflow_event, underflow_event;

    assign data_empty = (data_wr == data_rd);
    assign len_empty  = (len_wr == len_rd);

    assign accept      = daq_valid && daq_ready;
    assign rec_cnt_inc = rec_cnt + MAC_PACKET_BITS'(1);
    // A record closes on its marked last word or when it reaches the maximum size.
    assign commit      = accept && (daq_end || (rec_cnt_inc == MAC_PACKET_BITS'(MAX_RECORD)));

    // Pops on an empty FIFO are discarded here so pointers never move past the tail.
    assign data_pop = daqo_data_rd_en && !data_empty;
    assign len_pop  = daqo_len_rd_en && !len_empty;

    assign overflow_event  = daq_valid && !daq_ready;
    assign underflow_event = (daqo_data_rd_en && data_empty) || (daqo_len_rd_en && len_empty);

    assign data_wr_next = data_wr + (DATA_DEPTH_BITS+1)'(accept);
    assign data_rd_next = data_rd + (DATA_DEPTH_BITS+1)'(data_pop);
    assign len_wr_next  = len_wr + (LEN_DEPTH_BITS+1)'(commit);
    assign len_rd_next  = len_rd + (LEN_DEPTH_BITS+1)'(len_pop);

    assign data_full_next = (data_wr_next[DATA_DEPTH_BITS] != data_rd_next[DATA_DEPTH_BITS]) &&
                            (data_wr_next[DATA_DEPTH_BITS-1:0] == data_rd_next[DATA_DEPTH_BITS-1:0]);
    assign len_full_next  = (len_wr_next[LEN_DEPTH_BITS] != len_rd_next[LEN_DEPTH_BITS]) &&
                            (len_wr_next[LEN_DEPTH_BITS-1:0] == len_rd_next[LEN_DEPTH_BITS-1:0]);

    // Heads are shown only when non-empty, which also gives zero outputs during reset.
    assign daqo_data      = data_empty ? 32'd0 : data_mem[data_rd[DATA_DEPTH_BITS-1:0]];
    assign daqo_len       = len_empty ? '0 : len_mem[len_rd[LEN_DEPTH_BITS-1:0]];
    assign daqo_len_ready = !len_empty;

    always_ff @(posedge clk) begin
        if (accept)
            data_mem[data_wr[DATA_DEPTH_BITS-1:0]] <= daq_data;
        if (commit)
            len_mem[len_wr[LEN_DEPTH_BITS-1:0]] <= rec_cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_wr   <= '0;
            data_rd   <= '0;
            len_wr    <= '0;
            len_rd    <= '0;
            rec_cnt   <= '0;
            daq_ready <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            data_wr   <= data_wr_next;
            data_rd   <= data_rd_next;
            len_wr    <= len_wr_next;
            len_rd    <= len_rd_next;
            if (commit)
                rec_cnt <= '0;
            else if (accept)
                rec_cnt <= rec_cnt_inc;
            daq_ready <= !data_full_next && !len_full_next;
            overflow  <= (overflow && !clear_err) || overflow_event;
            underflow <= (underflow && !clear_err) || underflow_event;
        end
    end

endmodule

// File: tb/tb_daqo_queue.sv
// Bench for daqo_queue: a directed vector table, hand-written corner sequences and
// a randomized phase, all compared against a queue-based model of the record queue.
module tb_daqo_queue;

    localparam int MAX_RECORD = 375;
    localparam int DATA_DEPTH = 1024;
    localparam int LEN_DEPTH  = 16;

    logic        clk;
    logic        rst;
    logic [31:0] daq_data;
    logic        daq_valid;
    logic        daq_end;
    logic        daq_ready;
    logic [31:0] daqo_data;
    logic        daqo_data_rd_en;
    logic [8:0]  daqo_len;
    logic        daqo_len_ready;
    logic        daqo_len_rd_en;
    logic        clear_err;
    logic        overflow;
    logic        underflow;

    daqo_queue dut (
        .clk             (clk),
        .rst             (rst),
        .daq_data        (daq_data),
        .daq_valid       (daq_valid),
        .daq_end         (daq_end),
        .daq_ready       (daq_ready),
        .daqo_data       (daqo_data),
        .daqo_data_rd_en (daqo_data_rd_en),
        .daqo_len        (daqo_len),
        .daqo_len_ready  (daqo_len_ready),
        .daqo_len_rd_en  (daqo_len_rd_en),
        .clear_err       (clear_err),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queues of words and record lengths.
    logic [31:0] m_data[$];
    int          m_len[$];
    int          m_cnt;
    bit          m_ready, m_ovf, m_unf;

    typedef struct {
        logic        valid, last;
        logic [31:0] data;
        logic        data_rd, len_rd, clr;
        logic        exp_ready, exp_len_ready;
        logic        chk_len;
        logic [8:0]  exp_len;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_ovf, exp_unf;
    } vec_t;

    vec_t vecs[15];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data.delete();
        m_len.delete();
        m_cnt   = 0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic set_idle();
        daq_valid       = 1'b0;
        daq_end         = 1'b0;
        daq_data        = 32'd0;
        daqo_data_rd_en = 1'b0;
        daqo_len_rd_en  = 1'b0;
        clear_err       = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic e, input logic [31:0] d,
                                 input logic drd, input logic lrd, input logic clr);
        bit ovf_ev, unf_ev;
        daq_valid       = v;
        daq_end         = e;
        daq_data        = d;
        daqo_data_rd_en = drd;
        daqo_len_rd_en  = lrd;
        clear_err       = clr;
        @(posedge clk);
        ovf_ev = v && !m_ready;
        unf_ev = 1'b0;
        if (drd) begin
            if (m_data.size() == 0) unf_ev = 1'b1;
            else void'(m_data.pop_front());
        end
        if (lrd) begin
            if (m_len.size() == 0) unf_ev = 1'b1;
            else void'(m_len.pop_front());
        end
        if (v && m_ready) begin
            m_data.push_back(d);
            m_cnt++;
            if (e || m_cnt == MAX_RECORD) begin
                m_len.push_back(m_cnt);
                m_cnt = 0;
            end
        end
        m_ovf   = (m_ovf && !clr) || ovf_ev;
        m_unf   = (m_unf && !clr) || unf_ev;
        m_ready = (m_data.size() < DATA_DEPTH) && (m_len.size() < LEN_DEPTH);
        #1;
    endtask

    task automatic checkOutput(input string name);
        check_val({name, ".ready"}, 32'(daq_ready), 32'(m_ready));
        check_val({name, ".len_ready"}, 32'(daqo_len_ready), 32'(m_len.size() > 0));
        check_val({name, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check_val({name, ".underflow"}, 32'(underflow), 32'(m_unf));
        if (m_len.size() > 0)
            check_val({name, ".len"}, 32'(daqo_len), 32'(m_len[0]));
        if (m_data.size() > 0)
            check_val({name, ".data"}, daqo_data, m_data[0]);
    endtask

    task automatic check_reset_values(input string name);
        check_val({name, ".ready"}, 32'(daq_ready), 32'd0);
        check_val({name, ".len_ready"}, 32'(daqo_len_ready), 32'd0);
        check_val({name, ".len"}, 32'(daqo_len), 32'd0);
        check_val({name, ".data"}, daqo_data, 32'd0);
        check_val({name, ".overflow"}, 32'(overflow), 32'd0);
        check_val({name, ".underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        // valid last data  drd lrd clr | ready lrdy chkl len chkd data ovf unf
        vecs[0]  = '{1, 0, 32'h11, 0, 0, 0, 1, 0, 0, 9'd0, 1, 32'h11, 0, 0};
        vecs[1]  = '{1, 0, 32'h22, 0, 0, 0, 1, 0, 0, 9'd0, 1, 32'h11, 0, 0};
        vecs[2]  = '{1, 1, 32'h33, 0, 0, 0, 1, 1, 1, 9'd3, 1, 32'h11, 0, 0};
        vecs[3]  = '{0, 0, 32'h00, 1, 0, 0, 1, 1, 1, 9'd3, 1, 32'h22, 0, 0};
        vecs[4]  = '{0, 0, 32'h00, 1, 0, 0, 1, 1, 1, 9'd3, 1, 32'h33, 0, 0};
        vecs[5]  = '{0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 9'd0, 0, 32'h00, 0, 0};
        vecs[6]  = '{0, 0, 32'h00, 1, 0, 0, 1, 0, 0, 9'd0, 0, 32'h00, 0, 1};
        vecs[7]  = '{1, 1, 32'hA5, 0, 0, 0, 1, 1, 1, 9'd1, 1, 32'hA5, 0, 1};
        vecs[8]  = '{0, 0, 32'h00, 0, 0, 1, 1, 1, 1, 9'd1, 1, 32'hA5, 0, 0};
        vecs[9]  = '{0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 9'd0, 0, 32'h00, 0, 0};
        vecs[10] = '{1, 0, 32'hA6, 1, 0, 0, 1, 0, 0, 9'd0, 1, 32'hA6, 0, 1};
        vecs[11] = '{1, 1, 32'hA7, 0, 1, 1, 1, 1, 1, 9'd2, 1, 32'hA6, 0, 1};
        vecs[12] = '{0, 1, 32'h00, 0, 0, 1, 1, 1, 1, 9'd2, 1, 32'hA6, 0, 0};
        vecs[13] = '{0, 0, 32'h00, 1, 0, 0, 1, 1, 1, 9'd2, 1, 32'hA7, 0, 0};
        vecs[14] = '{0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 9'd0, 0, 32'h00, 0, 0};

        set_idle();
        rst = 1'b1;
        model_reset();
        #2;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        check_val("ready_after_reset", 32'(daq_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].data,
                          vecs[i].data_rd, vecs[i].len_rd, vecs[i].clr);
            check_val($sformatf("vec%0d.ready", i), 32'(daq_ready), 32'(vecs[i].exp_ready));
            check_val($sformatf("vec%0d.len_ready", i), 32'(daqo_len_ready), 32'(vecs[i].exp_len_ready));
            if (vecs[i].chk_len)
                check_val($sformatf("vec%0d.len", i), 32'(daqo_len), 32'(vecs[i].exp_len));
            if (vecs[i].chk_data)
                check_val($sformatf("vec%0d.data", i), daqo_data, vecs[i].exp_data);
            check_val($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check_val($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // 400-word stream with one end marker: forced split at the maximum record size
        for (int i = 1; i <= 400; i++) begin
            applyStimulus(1, i == 400, $urandom, 0, 0, 0);
            checkOutput("stream");
        end
        check_val("split.first_len", 32'(daqo_len), 32'd375);
        applyStimulus(0, 0, 32'd0, 0, 1, 0);
        check_val("split.second_len", 32'(daqo_len), 32'd25);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(0, 0, 32'd0, 1, i == 399, 0);
            checkOutput("stream_drain");
        end

        // Fill the data FIFO, then offer one more word
        for (int i = 0; i < DATA_DEPTH; i++) begin
            applyStimulus(1, 0, $urandom, 0, 0, 0);
            checkOutput("fill");
        end
        check_val("full.ready", 32'(daq_ready), 32'd0);
        applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check_val("full.overflow_set", 32'(overflow), 32'd1);
        checkOutput("full_drop");
        applyStimulus(0, 0, 32'd0, 0, 0, 1);
        check_val("full.overflow_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DATA_DEPTH; i++) begin
            applyStimulus(0, 0, 32'd0, 1, i < 2, 0);
            checkOutput("fill_drain");
        end

        // Reset in the middle of an unfinished record
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 0, 32'h100 + 32'(i), 0, 0, 0);
        set_idle();
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("post_reset");
        applyStimulus(1, 0, 32'h0BAD_0001, 0, 0, 0);
        applyStimulus(1, 1, 32'h0BAD_0002, 0, 0, 0);
        check_val("post_reset.len", 32'(daqo_len), 32'd2);
        checkOutput("post_reset_rec");
        applyStimulus(0, 0, 32'd0, 1, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 1, 0);
        checkOutput("post_reset_drain");

        // Sixteen one-word records fill the length FIFO
        for (int i = 0; i < LEN_DEPTH; i++) begin
            applyStimulus(1, 1, 32'h200 + 32'(i), 0, 0, 0);
            checkOutput("len_fill");
        end
        check_val("len_full.ready", 32'(daq_ready), 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 1, 0);
        check_val("len_pop.ready", 32'(daq_ready), 32'd1);
        for (int i = 0; i < LEN_DEPTH; i++) begin
            applyStimulus(0, 0, 32'd0, 1, i < LEN_DEPTH - 1, 0);
            checkOutput("len_drain");
        end
        applyStimulus(0, 0, 32'd0, 0, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom,
                          $urandom_range(0, 9) < 4, $urandom_range(0, 19) < 3,
                          $urandom_range(0, 19) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
